// File: rtl/chr_bg_ctrl.sv
// Character background write controller: CPU/fill arbitration on the name-table
// port, a straight-through bitmap port, and vblank-synchronised register commit.
module chr_bg_ctrl #(
  parameter int CHR_SIZE_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              cpu_address,
  input  logic [7:0]               cpu_din,
  input  logic                     cpu_chr_we,
  input  logic                     cpu_bitmap_we,
  input  logic                     fill_start,
  input  logic [CHR_SIZE_BITS-1:0] fill_x,
  input  logic [CHR_SIZE_BITS-1:0] fill_y,
  input  logic [CHR_SIZE_BITS:0]   fill_w,
  input  logic [CHR_SIZE_BITS:0]   fill_h,
  input  logic [7:0]               fill_value,
  output logic                     fill_busy,
  output logic                     fill_done,
  input  logic [31:0]              cfg_x,
  input  logic [31:0]              cfg_y,
  input  logic [31:0]              cfg_scale,
  input  logic [31:0]              cfg_palette0,
  input  logic [31:0]              cfg_palette1,
  input  logic [31:0]              cfg_palette2,
  input  logic [31:0]              cfg_palette3,
  input  logic                     commit_req,
  input  logic                     vblank,
  output logic                     commit_pending,
  output logic                     commit_done,
  output logic [31:0]              chr_address,
  output logic [7:0]               chr_din,
  output logic                     chr_we,
  output logic [31:0]              bitmap_address,
  output logic [7:0]               bitmap_din,
  output logic                     bitmap_we,
  output logic [31:0]              x,
  output logic [31:0]              y,
  output logic [31:0]              scale,
  output logic [31:0]              palette0,
  output logic [31:0]              palette1,
  output logic [31:0]              palette2,
  output logic [31:0]              palette3
);

  localparam int N = CHR_SIZE_BITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_t;

  fill_state_t state, state_nx;

  logic [N-1:0] fx_q, fy_q, col, row, col_nx, row_nx;
  logic [N:0]   fw_q, fh_q;
  logic [7:0]   fval_q;
  logic         zero_q;
  logic         zero_start, last_col, last_row, issue, fill_done_nx;
  logic [N-1:0] addr_row, addr_col;
  logic [31:0]  fill_addr;

  logic         vblank_q, pending, vb_edge;
  logic [31:0]  stg_x, stg_y, stg_scale, stg_pal0, stg_pal1, stg_pal2, stg_pal3;

  assign zero_start = (fill_w == '0) || (fill_h == '0);
  assign last_col   = ({1'b0, col} == (fw_q - (N+1)'(1)));
  assign last_row   = ({1'b0, row} == (fh_q - (N+1)'(1)));
  assign addr_row   = fy_q + row;
  assign addr_col   = fx_q + col;
  assign fill_addr  = 32'({addr_row, addr_col});
  assign vb_edge    = vblank & ~vblank_q;

  // A zero-size fill reports done straight from IDLE; a real fill reports it
  // from DONE so the pulse lands one cycle after its last registered write.
  always_comb begin
    state_nx     = state;
    col_nx       = col;
    row_nx       = row;
    issue        = 1'b0;
    fill_done_nx = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          col_nx = '0;
          row_nx = '0;
          if (zero_start) begin
            state_nx     = DONE;
            fill_done_nx = 1'b1;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (!cpu_chr_we) begin
          issue = 1'b1;
          if (last_col) begin
            col_nx = '0;
            if (last_row) state_nx = DONE;
            else          row_nx   = row + N'(1);
          end else begin
            col_nx = col + N'(1);
          end
        end
      end
      DONE: begin
        state_nx     = IDLE;
        fill_done_nx = ~zero_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      fx_q           <= '0;
      fy_q           <= '0;
      fw_q           <= '0;
      fh_q           <= '0;
      fval_q         <= '0;
      zero_q         <= 1'b0;
      fill_busy      <= 1'b0;
      fill_done      <= 1'b0;
      chr_we         <= 1'b0;
      chr_address    <= '0;
      chr_din        <= '0;
      bitmap_we      <= 1'b0;
      bitmap_address <= '0;
      bitmap_din     <= '0;
      vblank_q       <= 1'b0;
      pending        <= 1'b0;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
      stg_x          <= '0;
      stg_y          <= '0;
      stg_scale      <= '0;
      stg_pal0       <= '0;
      stg_pal1       <= '0;
      stg_pal2       <= '0;
      stg_pal3       <= '0;
      x              <= '0;
      y              <= '0;
      scale          <= '0;
      palette0       <= '0;
      palette1       <= '0;
      palette2       <= '0;
      palette3       <= '0;
    end else begin
      state     <= state_nx;
      col       <= col_nx;
      row       <= row_nx;
      fill_busy <= (state_nx == RUN);
      fill_done <= fill_done_nx;

      if (state == IDLE && fill_start) begin
        fx_q   <= fill_x;
        fy_q   <= fill_y;
        fw_q   <= fill_w;
        fh_q   <= fill_h;
        fval_q <= fill_value;
        zero_q <= zero_start;
      end

      if (cpu_chr_we) begin
        chr_we      <= 1'b1;
        chr_address <= cpu_address;
        chr_din     <= cpu_din;
      end else if (issue) begin
        chr_we      <= 1'b1;
        chr_address <= fill_addr;
        chr_din     <= fval_q;
      end else begin
        chr_we      <= 1'b0;
      end

      bitmap_we      <= cpu_bitmap_we;
      bitmap_address <= cpu_address;
      bitmap_din     <= cpu_din;

      // Apply-then-capture ordering lets a same-cycle request refill staging
      // after the old staging has gone live, keeping pending set.
      vblank_q    <= vblank;
      commit_done <= 1'b0;
      if (vb_edge && pending) begin
        x           <= stg_x;
        y           <= stg_y;
        scale       <= stg_scale;
        palette0    <= stg_pal0;
        palette1    <= stg_pal1;
        palette2    <= stg_pal2;
        palette3    <= stg_pal3;
        commit_done <= 1'b1;
        pending     <= 1'b0;
      end
      if (commit_req) begin
        stg_x     <= cfg_x;
        stg_y     <= cfg_y;
        stg_scale <= cfg_scale;
        stg_pal0  <= cfg_palette0;
        stg_pal1  <= cfg_palette1;
        stg_pal2  <= cfg_palette2;
        stg_pal3  <= cfg_palette3;
        pending   <= 1'b1;
      end
      commit_pending <= pending;
    end
  end

endmodule

// File: tb/tb_chr_bg_ctrl.sv
// Scoreboard bench for chr_bg_ctrl: expected name-table writes are queued as
// stimulus is driven and popped as chr_we appears.
module tb_chr_bg_ctrl;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  cpu_address;
  logic [7:0]   cpu_din;
  logic         cpu_chr_we, cpu_bitmap_we;
  logic         fill_start;
  logic [N-1:0] fill_x, fill_y;
  logic [N:0]   fill_w, fill_h;
  logic [7:0]   fill_value;
  logic         fill_busy, fill_done;
  logic [31:0]  cfg_x, cfg_y, cfg_scale, cfg_palette0, cfg_palette1, cfg_palette2, cfg_palette3;
  logic         commit_req, vblank, commit_pending, commit_done;
  logic [31:0]  chr_address, bitmap_address;
  logic [7:0]   chr_din, bitmap_din;
  logic         chr_we, bitmap_we;
  logic [31:0]  x, y, scale, palette0, palette1, palette2, palette3;

  chr_bg_ctrl #(.CHR_SIZE_BITS(N)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_din(cpu_din),
    .cpu_chr_we(cpu_chr_we), .cpu_bitmap_we(cpu_bitmap_we),
    .fill_start(fill_start), .fill_x(fill_x), .fill_y(fill_y),
    .fill_w(fill_w), .fill_h(fill_h), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_scale(cfg_scale),
    .cfg_palette0(cfg_palette0), .cfg_palette1(cfg_palette1),
    .cfg_palette2(cfg_palette2), .cfg_palette3(cfg_palette3),
    .commit_req(commit_req), .vblank(vblank),
    .commit_pending(commit_pending), .commit_done(commit_done),
    .chr_address(chr_address), .chr_din(chr_din), .chr_we(chr_we),
    .bitmap_address(bitmap_address), .bitmap_din(bitmap_din), .bitmap_we(bitmap_we),
    .x(x), .y(y), .scale(scale),
    .palette0(palette0), .palette1(palette1), .palette2(palette2), .palette3(palette3)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int done_cnt = 0, done_cyc = 0, last_we_cyc = 0, cd_cnt = 0;
  logic [39:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (chr_we === 1'b1) begin
      last_we_cyc = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("chr_address", 64'(chr_address), 64'(e[39:8]));
        chk("chr_din", 64'(chr_din), 64'(e[7:0]));
      end else begin
        chk("chr_unexpected_we", 64'(chr_we), 64'(0));
      end
    end
    if (fill_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (commit_done === 1'b1) cd_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic start_fill(input logic [N-1:0] fx, input logic [N-1:0] fy,
                            input logic [N:0] fw, input logic [N:0] fh,
                            input logic [7:0] v, output int s);
    fill_x = fx; fill_y = fy; fill_w = fw; fill_h = fh; fill_value = v;
    fill_start = 1'b1;
    s = cyc;
    step();
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int lim);
    int n = 0;
    while (done_cnt == prev && n < lim) begin
      step();
      n++;
    end
    step();
    chk("fill_done_seen", 64'(done_cnt), 64'(prev + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s, prev, cd0;

    // reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_address = $urandom; cpu_din = 8'($urandom);
      cpu_chr_we = 1'($urandom); cpu_bitmap_we = 1'($urandom);
      fill_start = 1'($urandom); fill_x = N'($urandom); fill_y = N'($urandom);
      fill_w = (N+1)'($urandom); fill_h = (N+1)'($urandom); fill_value = 8'($urandom);
      cfg_x = $urandom; cfg_y = $urandom; cfg_scale = $urandom;
      cfg_palette0 = $urandom; cfg_palette1 = $urandom;
      cfg_palette2 = $urandom; cfg_palette3 = $urandom;
      commit_req = 1'($urandom); vblank = 1'($urandom);
      step();
    end
    chk("rst_chr", {31'd0, chr_we, chr_address}, 64'(0));
    chk("rst_chr_din", 64'(chr_din), 64'(0));
    chk("rst_bitmap", {23'd0, bitmap_we, bitmap_din, bitmap_address}, 64'(0));
    chk("rst_fill_flags", {62'd0, fill_busy, fill_done}, 64'(0));
    chk("rst_commit_flags", {62'd0, commit_pending, commit_done}, 64'(0));
    chk("rst_xy", {x, y}, 64'(0));
    chk("rst_scale_pal0", {scale, palette0}, 64'(0));
    chk("rst_pal123", 64'(palette1 | palette2 | palette3), 64'(0));

    cpu_chr_we = 0; cpu_bitmap_we = 0; fill_start = 0; commit_req = 0; vblank = 0;
    cpu_address = 0; cpu_din = 0;
    reset = 1'b1;
    step();
    step();

    // CPU chr write, one cycle latency
    push(32'd5, 8'h12);
    cpu_address = 32'd5; cpu_din = 8'h12; cpu_chr_we = 1'b1;
    s = cyc;
    step();
    cpu_chr_we = 1'b0;
    step();
    chk("cpu_we_latency", 64'(last_we_cyc - s), 64'(1));

    // bitmap path
    cpu_address = 32'hDEAD_0001; cpu_din = 8'h5A; cpu_bitmap_we = 1'b1;
    step();
    cpu_bitmap_we = 1'b0;
    chk("bitmap_we", 64'(bitmap_we), 64'(1));
    chk("bitmap_addr_din", {24'd0, bitmap_din, bitmap_address}, {24'd0, 8'h5A, 32'hDEAD_0001});
    step();
    chk("bitmap_we_off", 64'(bitmap_we), 64'(0));

    // basic fill
    push(32'd194, 8'hA5); push(32'd195, 8'hA5); push(32'd196, 8'hA5);
    push(32'd258, 8'hA5); push(32'd259, 8'hA5); push(32'd260, 8'hA5);
    prev = done_cnt;
    start_fill(6'd2, 6'd3, 7'd3, 7'd2, 8'hA5, s);
    chk("basic_busy", 64'(fill_busy), 64'(1));
    wait_done(prev, 40);
    chk("basic_done_cyc", 64'(done_cyc - s), 64'(8));
    chk("basic_done_after_last_we", 64'(done_cyc - last_we_cyc), 64'(1));
    chk("basic_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("basic_busy_off", 64'(fill_busy), 64'(0));

    // wrap fill
    push(32'd4095, 8'h3E); push(32'd4032, 8'h3E); push(32'd63, 8'h3E); push(32'd0, 8'h3E);
    prev = done_cnt;
    start_fill(6'd63, 6'd63, 7'd2, 7'd2, 8'h3E, s);
    wait_done(prev, 40);
    chk("wrap_done_cyc", 64'(done_cyc - s), 64'(6));
    chk("wrap_queue_empty", 64'(exp_q.size()), 64'(0));

    // stall: CPU write on 2nd RUN cycle, fill_start during RUN ignored
    push(32'd640, 8'h3C); push(32'd7, 8'h99);
    push(32'd641, 8'h3C); push(32'd642, 8'h3C); push(32'd643, 8'h3C);
    prev = done_cnt;
    start_fill(6'd0, 6'd10, 7'd4, 7'd1, 8'h3C, s);
    step();
    cpu_address = 32'd7; cpu_din = 8'h99; cpu_chr_we = 1'b1;
    fill_x = 6'd1; fill_y = 6'd1; fill_w = 7'd1; fill_h = 7'd1; fill_start = 1'b1;
    step();
    cpu_chr_we = 1'b0; fill_start = 1'b0;
    wait_done(prev, 40);
    chk("stall_done_cyc", 64'(done_cyc - s), 64'(7));
    repeat (10) step();
    chk("stall_single_done", 64'(done_cnt), 64'(prev + 1));
    chk("stall_queue_empty", 64'(exp_q.size()), 64'(0));

    // zero-size fill
    prev = done_cnt;
    start_fill(6'd5, 6'd5, 7'd0, 7'd3, 8'h77, s);
    step();
    repeat (5) step();
    chk("zero_done_cyc", 64'(done_cyc - s), 64'(1));
    chk("zero_single_done", 64'(done_cnt), 64'(prev + 1));

    // reset during a fill aborts it
    push(32'd1280, 8'h11); push(32'd1281, 8'h11);
    prev = done_cnt;
    start_fill(6'd0, 6'd20, 7'd4, 7'd4, 8'h11, s);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (20) step();
    chk("abort_no_done", 64'(done_cnt), 64'(prev));
    chk("abort_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("abort_idle", {62'd0, chr_we, fill_busy}, 64'(0));

    // commit: last request wins
    cd0 = cd_cnt;
    cfg_x = 10; cfg_y = 11; cfg_scale = 12;
    cfg_palette0 = 13; cfg_palette1 = 14; cfg_palette2 = 15; cfg_palette3 = 16;
    commit_req = 1'b1;
    step();
    cfg_x = 20; cfg_y = 21; cfg_scale = 22;
    cfg_palette0 = 23; cfg_palette1 = 24; cfg_palette2 = 25; cfg_palette3 = 26;
    step();
    commit_req = 1'b0;
    step();
    chk("commit_hold_x", 64'(x), 64'(0));
    chk("commit_pending", 64'(commit_pending), 64'(1));
    vblank = 1'b1;
    step();
    chk("commit_x", 64'(x), 64'(20));
    chk("commit_y_scale", {y, scale}, {32'd21, 32'd22});
    chk("commit_pal01", {palette0, palette1}, {32'd23, 32'd24});
    chk("commit_pal23", {palette2, palette3}, {32'd25, 32'd26});
    chk("commit_done", 64'(commit_done), 64'(1));
    step();
    chk("commit_done_pulse", 64'(commit_done), 64'(0));
    repeat (3) step();
    chk("commit_done_once", 64'(cd_cnt), 64'(cd0 + 1));
    chk("commit_pending_clear", 64'(commit_pending), 64'(0));

    // request on the edge with nothing pending waits for the next edge
    vblank = 1'b0;
    step();
    cfg_x = 30;
    commit_req = 1'b1; vblank = 1'b1;
    step();
    commit_req = 1'b0;
    chk("coincide_x_hold", 64'(x), 64'(20));
    chk("coincide_no_done", 64'(commit_done), 64'(0));
    step();
    chk("coincide_pending", 64'(commit_pending), 64'(1));
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    step();
    chk("coincide_x_next_edge", 64'(x), 64'(30));
    chk("coincide_done", 64'(commit_done), 64'(1));
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/chr_bg_ctrl.md
# chr_bg_ctrl

Write-side controller for the character background layer. It sits in the `clk` domain between the CPU bus and the background layer's name-table/bitmap write ports and its scroll/scale/palette inputs. It arbitrates single CPU writes against a hardware rectangle-fill engine on the name-table port. It also holds staged scroll/scale/palette values and commits them atomically on the next vertical-blank edge, so the display never samples a half-updated register set.

## Interface
- `CHR_SIZE_BITS`, 6, log2 of name-table width/height in tiles; address = row·2^CHR_SIZE_BITS + col.
- `clk` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-low (0 = reset), sampled on `clk` rising edge.
- `cpu_address` in 32: CPU write address.
- `cpu_din` in 8: CPU write data.
- `cpu_chr_we` in 1: CPU name-table write strobe.
- `cpu_bitmap_we` in 1: CPU bitmap write strobe.
- `fill_start` in 1: one-cycle pulse; starts a fill.
- `fill_x`, `fill_y` in CHR_SIZE_BITS: top-left tile.
- `fill_w`, `fill_h` in CHR_SIZE_BITS+1: size in tiles, 0..2^CHR_SIZE_BITS.
- `fill_value` in 8: tile name written.
- `fill_busy` out 1: fill in progress.
- `fill_done` out 1: one-cycle completion pulse.
- `cfg_x`, `cfg_y`, `cfg_scale`, `cfg_palette0..3` in 32 each: staged register values.
- `commit_req` in 1: one-cycle pulse; capture `cfg_*` and arm a commit.
- `vblank` in 1: vertical-blank level, already in the `clk` domain.
- `commit_pending` out 1: a commit is armed.
- `commit_done` out 1: one-cycle pulse when the commit is applied.
- `chr_address` out 32, `chr_din` out 8, `chr_we` out 1: name-table write port.
- `bitmap_address` out 32, `bitmap_din` out 8, `bitmap_we` out 1: bitmap write port.
- `x`, `y`, `scale`, `palette0..3` out 32 each: live values to the background layer.

## Operation
- **Reset**
  - Every output is 0.
  - Fill FSM goes to IDLE and the pending flag clears.
  - A reset during a fill aborts it: no further writes and no `fill_done`.
- **Bitmap path:** `cpu_bitmap_we` is registered straight through to `bitmap_*` and is never stalled.
- **Fill FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on `fill_start`. The block latches the fill parameters and clears counters col=row=0.
  - IDLE → DONE instead if `fill_w`==0 or `fill_h`==0. No writes are issued.
  - `fill_start` is ignored while not in IDLE.
- **RUN**
  - In each cycle with `cpu_chr_we`=0, the block issues one write: value `fill_value`, address ((fill_y+row) mod 2^N)·2^N + ((fill_x+col) mod 2^N), where N = CHR_SIZE_BITS. Addresses wrap at the table edges.
  - After each write, col increments. At col==w−1, col←0 and row increments.
  - After the write at (w−1, h−1), the FSM goes to DONE.
  - The CPU has priority: a cycle with `cpu_chr_we`=1 forwards the CPU write, and the fill holds its counters that cycle.
- **DONE:** `fill_done`=1 for one cycle, `fill_busy`=0, then the FSM returns to IDLE. `fill_busy`=1 exactly while in RUN.
- **Commit**
  - `commit_req` copies `cfg_*` into staging registers and sets pending.
  - A vblank rising edge is `vblank`=1 with the previous cycle's `vblank`=0.
  - On a rising edge with pending=1, the block copies staging to `x..palette3`, pulses `commit_done` and clears pending.
  - A repeated `commit_req` before the edge overwrites staging (last one wins).
  - `commit_req` on the same cycle as an edge:
    - If pending was 0, the new values are captured but not applied until the next edge; pending becomes 1.
    - If pending was 1, the old staging is applied, the new values are captured, and pending stays 1.

## Timing
- All outputs are registered.
- CPU write presented at cycle t appears on `chr_*` or `bitmap_*` at t+1.
- `fill_start` at cycle t gives `fill_busy`=1 at t+1. The first fill write is on `chr_*` at t+2, since it is issued in RUN and registered.
- An unstalled fill takes w·h consecutive `chr_we` cycles. `fill_done` is asserted in the cycle after the last `chr_we`. Each CPU chr write during RUN adds exactly one cycle.
- A zero-size fill: `fill_start` at t gives `fill_done` at t+1 and no writes.
- Vblank edge at cycle t gives new `x..palette3` and `commit_done` at t+1.
- `commit_pending` follows pending with one cycle of register delay.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with random inputs → all outputs 0. Release and issue CPU chr write addr 5, data 0x12 → `chr_we`=1, `chr_address`=5, `chr_din`=0x12 one cycle later.
- **Basic fill:** x=2, y=3, w=3, h=2, value 0xA5 → 6 consecutive writes to 194, 195, 196, 258, 259, 260 → `fill_done` the next cycle.
- **Wrap fill:** x=63, y=63, w=2, h=2 → writes to 4095, 4032, 63, 0.
- **Stall:** fill w=4, h=1 with CPU chr write addr 7 injected on the 2nd RUN cycle → `chr_*` sequence is fill, CPU(7), fill, fill, fill → `fill_done` delayed by 1 cycle. A `fill_start` during RUN is ignored.
- **Zero size:** w=0 → no `chr_we` and `fill_done` one cycle after start. `fill_start` at cycle t, reset at t+3 → no `fill_done`, `chr_we`=0 thereafter.
- **Commit:**
  - `commit_req` with cfg_x=10, then `commit_req` with cfg_x=20, then vblank edge → `x`=20 and `commit_done` once.
  - `commit_req` coinciding with a vblank edge, pending=0 → no change until the next edge.
